// File: rtl/instr_load_buffer_pkg.sv
// Shared types and default sizing for the instruction load buffer.
package ibuf_pkg;

  localparam int IBUF_WORD_W = 32;
  localparam int IBUF_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } ibuf_state_e;

endpackage

// File: rtl/instr_load_buffer_if.sv
// Bus bundle for instr_load_buffer: write/read ports, status flags and FSM debug state.
interface instr_load_buffer_if
  import ibuf_pkg::*;
#(
  parameter int WORD_W = IBUF_WORD_W,
  parameter int DEPTH  = IBUF_DEPTH
);
  localparam int IDX_W = $clog2(DEPTH);

  // Write handshake: a word transfers on a rising clk edge where wr_valid && wr_ready;
  // wr_ready never depends on wr_valid, and a clear in the same cycle drops the word.
  logic              wr_valid;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0] wr_data;

  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_perr;

  logic              clear;
  logic [IDX_W:0]    fill_cnt;
  logic              full;
  logic              empty;
  logic              start;
  logic              running;
  ibuf_state_e       dbg_state;

  modport master (
    output wr_valid, wr_idx, wr_data, rd_en, rd_idx, clear,
    input  wr_ready, rd_data, rd_valid, rd_perr, fill_cnt, full, empty,
           start, running, dbg_state
  );

  modport slave (
    input  wr_valid, wr_idx, wr_data, rd_en, rd_idx, clear,
    output wr_ready, rd_data, rd_valid, rd_perr, fill_cnt, full, empty,
           start, running, dbg_state
  );

endinterface

// File: rtl/instr_load_buffer_mem.sv
// Instruction storage: one write port, one registered read port (read-before-write).
// With IBUF_PARITY_EN defined each entry also keeps an even-parity bit checked on read.
module ibuf_mem #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              perr_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[ridx_i];
  end

  assign rdata_o = rdata_q;

`ifdef IBUF_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             rpar_q;

  always_ff @(posedge clk) begin
    if (we_i) par_q[widx_i] <= ^wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rpar_q <= 1'b0;
    else if (re_i) rpar_q <= par_q[ridx_i];
  end

  assign perr_o = (^rdata_q) != rpar_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/instr_load_buffer.sv
// Instruction load buffer: fill entries by index until a zero marker or full, then RUN.
// Optional per-entry parity is enabled by defining IBUF_PARITY_EN.
module instr_load_buffer
  import ibuf_pkg::*;
#(
  parameter int WORD_W = IBUF_WORD_W,
  parameter int DEPTH  = IBUF_DEPTH
) (
  input logic               clk,
  input logic               rst,
  instr_load_buffer_if.slave bus
);

  localparam int             IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  ibuf_state_e       state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              rd_valid_q;
  logic              wr_acc, wr_marker, wr_store;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_perr;

  assign wr_acc    = bus.wr_valid && (state_q != RUN) && !bus.clear;
  assign wr_marker = wr_acc && (bus.wr_data == '0);
  assign wr_store  = wr_acc && (bus.wr_data != '0);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = IDLE;
      valid_d = '0;
      cnt_d   = '0;
    end else if (wr_marker) begin
      state_d = RUN;
    end else if (wr_store) begin
      valid_d[bus.wr_idx] = 1'b1;
      if (!valid_q[bus.wr_idx]) cnt_d = cnt_q + 1'b1;
      state_d = (cnt_d == FULL_CNT) ? RUN : FILL;
    end
    // start is registered so it lands on the first RUN cycle only
    start_d = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      rd_valid_q <= bus.rd_en && valid_q[bus.rd_idx];
    end
  end

  ibuf_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_store),
    .widx_i  (bus.wr_idx),
    .wdata_i (bus.wr_data),
    .re_i    (bus.rd_en),
    .ridx_i  (bus.rd_idx),
    .rdata_o (mem_rdata),
    .perr_o  (mem_perr)
  );

  // Unloaded entries read as zero regardless of stale array contents
  assign bus.rd_data   = rd_valid_q ? mem_rdata : '0;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_perr   = rd_valid_q & mem_perr;
  assign bus.wr_ready  = (state_q != RUN);
  assign bus.fill_cnt  = cnt_q;
  assign bus.full      = (cnt_q == FULL_CNT);
  assign bus.empty     = (cnt_q == '0);
  assign bus.start     = start_q;
  assign bus.running   = (state_q == RUN);
  assign bus.dbg_state = state_q;

endmodule

// File: doc/instr_load_buffer.md
INSTR_LOAD_BUFFER -- requirements
Module: instr_load_buffer

Interface
REQ-001 The module SHALL have parameter WORD_W, default 32, meaning instruction word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning entry count (power of two, >= 2); IDX_W = clog2(DEPTH).
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port wr_valid, input, 1, write request.
REQ-006 Port wr_ready, output, 1, write accepted this cycle when high with wr_valid.
REQ-007 Port wr_idx, input, IDX_W, write entry index.
REQ-008 Port wr_data, input, WORD_W, instruction word; all-zero word is the end-of-stream marker.
REQ-009 Port rd_en, input, 1, read request.
REQ-010 Port rd_idx, input, IDX_W, read entry index.
REQ-011 Port rd_data, output, WORD_W, registered read data.
REQ-012 Port rd_valid, output, 1, rd_data valid and addressed entry was loaded.
REQ-013 Port rd_perr, output, 1, parity error on current read (see Configuration).
REQ-014 Port clear, input, 1, synchronous flush back to IDLE.
REQ-015 Port fill_cnt, output, IDX_W+1, number of loaded entries.
REQ-016 Port full, output, 1, fill_cnt == DEPTH; empty, output, 1, fill_cnt == 0.
REQ-017 Port start, output, 1, single-cycle pulse on entry to RUN; running, output, 1, high while in RUN.

Function
REQ-018 FSM states SHALL be IDLE, FILL, RUN; per-entry valid bit replaces nonzero-word detection.
REQ-019 IDLE: wr_ready=1; accepted nonzero write stores word, sets valid, goes FILL.
REQ-020 FILL: wr_ready=1; accepted write to unloaded entry increments fill_cnt; to loaded entry overwrites data, fill_cnt unchanged.
REQ-021 Accepted zero word (IDLE or FILL) SHALL not be stored and SHALL move to RUN next cycle.
REQ-022 Write that makes fill_cnt reach DEPTH SHALL move to RUN next cycle.
REQ-023 start SHALL pulse exactly one cycle, the first cycle in RUN; running high for all RUN cycles.
REQ-024 RUN: wr_ready=0, writes ignored; leaves RUN only via clear or rst.
REQ-025 Reads SHALL be allowed in every state, latency 1: rd_en at edge N gives rd_data/rd_valid at edge N+1; rd_valid=0 otherwise.
REQ-026 Read of unloaded entry SHALL return rd_data=0, rd_valid=0.
REQ-027 Same-cycle read and write to same index SHALL return the pre-write contents.
REQ-028 clear SHALL zero all valid bits, fill_cnt, stop any pending start, go IDLE; clear with concurrent write: clear wins, write dropped.
REQ-029 Zero-marker written while empty SHALL enter RUN with fill_cnt=0, empty=1.

Reset
REQ-030 rst SHALL asynchronously clear state to IDLE, all valid bits, fill_cnt=0, rd_data=0, rd_valid=0, rd_perr=0, start=0, running=0; wr_ready=1 after release.
REQ-031 rst mid-FILL or mid-RUN SHALL discard all contents; stored data words need not be zeroed.

Configuration
REQ-032 Macro IBUF_PARITY_EN defined: each entry SHALL store an even-parity bit computed on write; rd_perr=1 with rd_valid when recomputed parity mismatches.
REQ-033 Macro IBUF_PARITY_EN undefined: no parity storage, rd_perr tied 0.

Structure
REQ-034 Package ibuf_pkg SHALL hold state enum (IDLE/FILL/RUN) and default WORD_W/DEPTH constants.
REQ-035 Sub-module ibuf_mem SHALL hold the data/parity array with one registered read port and one write port; FSM, valid bits and counter stay in top.

Verification
REQ-036 Reset, write idx 0..15 with 0x1000+idx -> fill_cnt=16, full=1, start pulse one cycle after last write, wr_ready=0.
REQ-037 Write idx3=0xDEAD, idx5=0xBEEF, then 0x0 -> RUN, fill_cnt=2; read idx5 -> next cycle rd_data=0xBEEF rd_valid=1; read idx4 -> rd_valid=0.
REQ-038 Write idx2=0xAAAA twice then 0xBBBB -> fill_cnt=1, read idx2 = 0xBBBB.
REQ-039 Same-cycle write idx7=0x55 over 0x11 and read idx7 -> rd_data=0x11; next read 0x55.
REQ-040 In RUN assert clear with write -> IDLE, fill_cnt=0, write dropped; assert rst mid-FILL -> all outputs at reset values immediately.
REQ-041 With IBUF_PARITY_EN, force one stored bit flip at idx1 -> read idx1 gives rd_perr=1; without macro rd_perr=0.
